// File: rtl/phy_tx_arbiter.sv
// rtl/phy_tx_arbiter.sv - round-robin burst arbiter in front of the PHY transmit datapath
//
// Ports:
//   clk_f      transmit word clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  per-requester word valid
//   req_data   requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-requester accept (one-hot or zero)
//   phy_ready  PHY accepts data_out this cycle
//   data_out   registered word to PHY data_in
//   valid_out  registered valid to PHY valid_in
//   grant_id   current or last granted requester
//   busy       high while a burst is in progress
//
// Optional feature macro: PHY_ARB_PRIORITY_EN (requester 0 high priority)
module phy_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_f,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          phy_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic [2:0]                    grant_id,
    output logic                          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              grant_nxt;
    logic [3:0]              burst_cnt, cnt_nxt, cnt_inc;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic                    valid_nxt;
    logic                    out_free;
    logic                    xfer;
    logic                    found;
    logic [2:0]              winner;
    logic [2:0]              cand;

    // Requester views padded to 8 entries so a 3-bit grant index always
    // selects in range, whatever NUM_REQ is.
    logic [7:0]              valid8;
    logic [DATA_WIDTH-1:0]   words [8];

    assign valid8 = 8'(req_valid);

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_words
            if (g < NUM_REQ) begin : g_real
                assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign words[g] = '0;
            end
        end
    endgenerate

    assign out_free = !valid_out || phy_ready;
    assign xfer     = (state == BURST) && valid8[grant_id] && out_free;
    assign busy     = (state == BURST);
    assign cnt_inc  = burst_cnt + 4'd1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == BURST) && (grant_id == 3'(i)) && out_free;
        end
    end

    // Round-robin search beginning one past the last grant, wrapping at NUM_REQ-1.
    always_comb begin
        found  = 1'b0;
        winner = grant_id;
        cand   = grant_id;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == 3'(NUM_REQ - 1)) ? 3'd0 : cand + 3'd1;
            if (!found && valid8[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef PHY_ARB_PRIORITY_EN
        // Requester 0 jumps the queue, except directly after its own burst,
        // so the others still get every other grant while it stays busy.
        if (valid8[0] && grant_id != 3'd0) begin
            found  = 1'b1;
            winner = 3'd0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        cnt_nxt   = burst_cnt;
        data_nxt  = data_out;
        valid_nxt = valid_out;

        // The PHY took the word and nothing replaces it: drop valid.
        if (phy_ready && !xfer) begin
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = winner;
                    cnt_nxt   = 4'd0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    data_nxt  = words[grant_id];
                    valid_nxt = 1'b1;
                    cnt_nxt   = cnt_inc;
                    if (cnt_inc == 4'(MAX_BURST)) begin
                        state_nxt = IDLE;
                    end
                end else if (!valid8[grant_id]) begin
                    // Requester ran dry; any word still held in data_out
                    // stays there until the PHY takes it.
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant_id  <= 3'(NUM_REQ - 1);
            burst_cnt <= 4'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            burst_cnt <= cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
        end
    end

endmodule
